// File: rtl/mem_arbiter_if.sv
// mem_arbiter bus interface
// IF/MEM request side, memory side and pipe status
interface mem_arbiter_if;
    logic        if_rd_n;
    logic [31:0] if_addr;
    logic [2:0]  mem_ctrl;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_rd_n;
    logic        ram_wr_n;
    logic        ram_wh;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        stall_pipe;

    modport slave (
        input  if_rd_n, if_addr, mem_ctrl, mem_addr, mem_wdata, ram_rdata,
        output ram_addr, ram_wdata, ram_rd_n, ram_wr_n, ram_wh,
        output if_rdata, if_valid, mem_rdata, mem_valid, stall_pipe
    );

    modport master (
        output if_rd_n, if_addr, mem_ctrl, mem_addr, mem_wdata, ram_rdata,
        input  ram_addr, ram_wdata, ram_rd_n, ram_wr_n, ram_wh,
        input  if_rdata, if_valid, mem_rdata, mem_valid, stall_pipe
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter for IF and MEM stages
// data has priority; fixed wait cycles; sticky done flags drive stall
module mem_arbiter #(
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DBUSY = 2'd1;
    localparam logic [1:0] IBUSY = 2'd2;
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_d_done;
    logic        r_i_done;
    logic [31:0] r_ram_addr;
    logic [31:0] r_ram_wdata;
    logic        r_ram_rd_n;
    logic        r_ram_wr_n;
    logic        r_ram_wh;
    logic [31:0] r_if_rdata;
    logic [31:0] r_mem_rdata;

    logic w_d_req;
    logic w_i_req;
    logic w_d_pend;
    logic w_i_pend;
    logic w_stall;

    assign w_d_req  = ~bus.mem_ctrl[2] | ~bus.mem_ctrl[1];
    assign w_i_req  = ~bus.if_rd_n;
    assign w_d_pend = w_d_req & ~r_d_done;
    assign w_i_pend = w_i_req & ~r_i_done;
    assign w_stall  = w_d_pend | w_i_pend;

    // grant, wait-count and complete one access at a time
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_d_done    <= 1'b0;
            r_i_done    <= 1'b0;
            r_ram_addr  <= 32'd0;
            r_ram_wdata <= 32'd0;
            r_ram_rd_n  <= 1'b1;
            r_ram_wr_n  <= 1'b1;
            r_ram_wh    <= 1'b1;
            r_if_rdata  <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else begin
            if (!w_stall) begin
                r_d_done <= 1'b0;
                r_i_done <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_d_pend) begin
                        r_state     <= DBUSY;
                        r_cnt       <= LAT_M1;
                        r_ram_addr  <= bus.mem_addr;
                        r_ram_wdata <= bus.mem_wdata;
                        r_ram_wh    <= bus.mem_ctrl[0];
                        r_ram_rd_n  <= bus.mem_ctrl[2];
                        r_ram_wr_n  <= ~bus.mem_ctrl[2];
                    end else if (w_i_pend) begin
                        r_state     <= IBUSY;
                        r_cnt       <= LAT_M1;
                        r_ram_addr  <= bus.if_addr;
                        r_ram_wdata <= bus.mem_wdata;
                        r_ram_wh    <= bus.mem_ctrl[0];
                        r_ram_rd_n  <= 1'b0;
                        r_ram_wr_n  <= 1'b1;
                    end
                end
                DBUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_d_done <= 1'b1;
                        if (!r_ram_rd_n) begin
                            r_mem_rdata <= bus.ram_rdata;
                        end
                        r_ram_rd_n <= 1'b1;
                        r_ram_wr_n <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                IBUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_i_done   <= 1'b1;
                        r_if_rdata <= bus.ram_rdata;
                        r_ram_rd_n <= 1'b1;
                        r_ram_wr_n <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_wdata  = r_ram_wdata;
    assign bus.ram_rd_n   = r_ram_rd_n;
    assign bus.ram_wr_n   = r_ram_wr_n;
    assign bus.ram_wh     = r_ram_wh;
    assign bus.if_rdata   = r_if_rdata;
    assign bus.if_valid   = r_i_done;
    assign bus.mem_rdata  = r_mem_rdata;
    assign bus.mem_valid  = r_d_done;
    assign bus.stall_pipe = w_stall;
endmodule
